// File: rtl/timer_compare_datapath.sv
// Operand/result registers, binary ALU, iteration counter and sticky match flag for the timer-compare controller.
// Controls act on the next clk edge; Az/c7 are combinational from R/counter; no backpressure, one action per cycle.
module timer_compare_datapath #(
    parameter int WIDTH    = 24,
    parameter int CNT_W    = 3,
    parameter int CNT_LAST = 7,
    parameter int MCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cur_time,
    input  logic [WIDTH-1:0]  tgt_time,
    input  logic              La,
    input  logic              Lb,
    input  logic              Ea,
    input  logic              Er,
    input  logic              Lr,
    input  logic              Kc,
    input  logic              Cc,
    input  logic              M,
    input  logic              Cin,
    input  logic [1:0]        s,
    input  logic              ack,
    output logic              Az,
    output logic              c7,
    output logic [WIDTH-1:0]  a_q,
    output logic [WIDTH-1:0]  r_q,
    output logic              cout_q,
    output logic [CNT_W-1:0]  cnt_q,
    output logic              match,
    output logic [MCNT_W-1:0] match_cnt
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   alu;
    logic [WIDTH:0]   cin_ext;

    assign cin_ext = (WIDTH+1)'(Cin);

    // ALU sees pre-edge A and B, so a same-cycle La never feeds R.
    always_comb begin
        alu = '0;
        case (s)
            2'b00:   alu = {1'b0, a_q} + cin_ext;
            2'b01:   alu = {1'b0, a_q} + {1'b0, b_q} + cin_ext;
            2'b10:   alu = {1'b0, a_q} + {1'b0, ~b_q} + cin_ext;
            default: alu = {1'b0, a_q ^ b_q};
        endcase
    end

    assign Az = (r_q == '0);
    assign c7 = (cnt_q == CNT_W'(CNT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (La)
                a_q <= cur_time;
            else if (Ea)
                a_q <= r_q;
            if (Lb)
                b_q <= tgt_time;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            cout_q <= 1'b0;
        end else if (Lr) begin
            r_q    <= '0;
            cout_q <= 1'b0;
        end else if (Er) begin
            r_q    <= alu[WIDTH-1:0];
            cout_q <= alu[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (Kc)
            cnt_q <= '0;
        else if (Cc)
            cnt_q <= c7 ? '0 : cnt_q + 1'b1;
    end

    // M wins over ack so a strobe arriving with the acknowledge is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (M)
                match <= 1'b1;
            else if (ack)
                match <= 1'b0;
            if (M && (match_cnt != '1))
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule
